// File: rtl/arb_pkg.sv
// Shared types for the 4-way round-robin arbiter.
// Optional hold limit: define ARB_HOLD_LIMIT_EN.
package arb_pkg;

    localparam int ARB_N = 4;

    typedef logic [1:0] arb_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_GAP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester/arbiter handshake bundle.
// Master drives requests; slave (arbiter) drives grants.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic             ena;
    logic [ARB_N-1:0] req;
    logic [ARB_N-1:0] grant;
    arb_idx_t         grant_idx;
    logic             busy;
    logic             hold_expired;

    modport master (
        output ena,
        output req,
        input  grant,
        input  grant_idx,
        input  busy,
        input  hold_expired
    );

    modport slave (
        input  ena,
        input  req,
        output grant,
        output grant_idx,
        output busy,
        output hold_expired
    );

endinterface

// File: rtl/decoder_2_to_4.sv
// 2-to-4 one-hot decoder with enable.
// All outputs are zero while ena is low.
module decoder_2_to_4 (
    input  logic       ena,
    input  logic [1:0] in,
    output logic [3:0] out
);

    always_comb begin
        out = 4'b0000;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_4_pick.sv
// Rotating-priority pick: first requester at or after ptr.
// Combinational; pick is don't-care when any is low.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  arb_idx_t         ptr,
    output arb_idx_t         pick,
    output logic             any
);

    arb_idx_t idx;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        any  = |req;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            idx = arb_idx_t'(ptr + arb_idx_t'(k));
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter, 4 requesters, one-cycle gap between owners.
// Define ARB_HOLD_LIMIT_EN to revoke grants after MAX_HOLD cycles.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter_4_if.slave   bus
);

    arb_state_t state_q, state_d;
    arb_idx_t   ptr_q, ptr_d;
    arb_idx_t   idx_q, idx_d;
    arb_idx_t   pick;
    logic       any;
    logic       release_owner;
    logic       expire;

    rr_pick4 u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    decoder_2_to_4 u_dec (
        .ena (state_q == ARB_BUSY),
        .in  (idx_q),
        .out (bus.grant)
    );

    assign bus.grant_idx = idx_q;
    assign bus.busy      = (state_q == ARB_BUSY);
    assign release_owner = !bus.req[idx_q];

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt_q;
    logic          he_q;

    assign expire = bus.req[idx_q]
                 && (hold_cnt_q == HW'(MAX_HOLD - 1));

    // Zero on every non-BUSY cycle, so it reads 0 on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            he_q       <= 1'b0;
        end else begin
            hold_cnt_q <= (state_q == ARB_BUSY) ? hold_cnt_q + HW'(1) : '0;
            he_q       <= (state_q == ARB_BUSY) && expire;
        end
    end

    assign bus.hold_expired = he_q;
`else
    assign expire           = 1'b0;
    assign bus.hold_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.ena && any) begin
                    idx_d   = pick;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Releasing owner drops to lowest priority.
                if (release_owner || expire) begin
                    ptr_d   = arb_idx_t'(idx_q + 2'd1);
                    state_d = ARB_GAP;
                end
            end
            ARB_GAP: begin
                if (bus.ena && any) begin
                    idx_d   = pick;
                    state_d = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=4).
// Hold-limit checks follow ARB_HOLD_LIMIT_EN.
module tb_rr_arbiter_4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] e(
        input logic [3:0] g,
        input logic       b,
        input logic       h,
        input logic [1:0] i
    );
        return {g, b, h, i};
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {bus.grant, bus.busy, bus.hold_expired, bus.grant_idx};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %b want %b (grant busy he idx)",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] g;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.ena = 1'b0;
        bus.req = 4'b0000;
        #3;
        chk("reset", e(4'b0000, 0, 0, 2'd0));
        step();
        step();
        chk("reset held", e(4'b0000, 0, 0, 2'd0));
        rst_n = 1'b1;

        // T1: single requester, release, ptr becomes 3
        bus.ena = 1'b1;
        bus.req = 4'b0100;
        step();
        chk("t1 grant", e(4'b0100, 1, 0, 2'd2));
        bus.req = 4'b0000;
        step();
        chk("t1 gap", e(4'b0000, 0, 0, 2'd2));
        step();
        chk("t1 idle", e(4'b0000, 0, 0, 2'd2));
        bus.req = 4'b1111;
        step();
        chk("t1 ptr3", e(4'b1000, 1, 0, 2'd3));
        bus.req = 4'b0000;
        step();
        step();
        chk("t1 back idle", e(4'b0000, 0, 0, 2'd3));

        // T2: all requesting, each owner holds 2 cycles
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("t2 reset", e(4'b0000, 0, 0, 2'd0));
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001 << (i % 4);
            step();
            chk($sformatf("t2 own%0d a", i), e(g, 1, 0, 2'(i % 4)));
            step();
            chk($sformatf("t2 own%0d b", i), e(g, 1, 0, 2'(i % 4)));
            bus.req = 4'b1111 & ~g;
            step();
            chk($sformatf("t2 gap%0d", i), e(4'b0000, 0, 0, 2'(i % 4)));
            bus.req = 4'b1111;
        end
        bus.req = 4'b0000;
        step();
        chk("t2 idle", e(4'b0000, 0, 0, 2'd0));

        // T3: owner 2, no preemption, then wrap to 0
        bus.req = 4'b0100;
        step();
        chk("t3 own2", e(4'b0100, 1, 0, 2'd2));
        bus.req = 4'b0101;
        step();
        chk("t3 no preempt", e(4'b0100, 1, 0, 2'd2));
        bus.req = 4'b0001;
        step();
        chk("t3 gap", e(4'b0000, 0, 0, 2'd2));
        step();
        chk("t3 wrap", e(4'b0001, 1, 0, 2'd0));
        bus.req = 4'b0000;
        step();
        step();

        // Released owner re-requesting in GAP loses
        bus.req = 4'b0011;
        step();
        chk("rr own1", e(4'b0010, 1, 0, 2'd1));
        bus.req = 4'b0001;
        step();
        chk("rr gap", e(4'b0000, 0, 0, 2'd1));
        bus.req = 4'b0011;
        step();
        chk("rr lowest", e(4'b0001, 1, 0, 2'd0));
        bus.req = 4'b0000;
        step();
        step();

        // T4: ena gating
        bus.ena = 1'b0;
        bus.req = 4'b0010;
        step();
        step();
        chk("t4 blocked", e(4'b0000, 0, 0, 2'd0));
        bus.ena = 1'b1;
        step();
        chk("t4 grant", e(4'b0010, 1, 0, 2'd1));
        bus.ena = 1'b0;
        step();
        step();
        chk("t4 ena low hold", e(4'b0010, 1, 0, 2'd1));
        bus.req = 4'b0000;
        step();
        chk("t4 gap", e(4'b0000, 0, 0, 2'd1));
        step();
        bus.ena = 1'b1;

        // T5: async reset mid-BUSY
        bus.req = 4'b1000;
        step();
        chk("t5 own3", e(4'b1000, 1, 0, 2'd3));
        rst_n = 1'b0;
        #1;
        chk("t5 async drop", e(4'b0000, 0, 0, 2'd0));
        bus.req = 4'b1010;
        step();
        chk("t5 in reset", e(4'b0000, 0, 0, 2'd0));
        rst_n = 1'b1;
        step();
        chk("t5 after reset", e(4'b0010, 1, 0, 2'd1));
        bus.req = 4'b0000;
        step();
        step();

        // T6: hold limit behaviour
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req = 4'b0011;
`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6 hold%0d", i), e(4'b0001, 1, 0, 2'd0));
        end
        step();
        chk("t6 expired", e(4'b0000, 0, 1, 2'd0));
        step();
        chk("t6 next", e(4'b0010, 1, 0, 2'd1));
`else
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t6 hold%0d", i), e(4'b0001, 1, 0, 2'd0));
        end
`endif
        bus.req = 4'b0000;
        step();
        step();
        chk("final idle", e(4'b0000, 0, 0, bus.grant_idx === 2'd1 ? 2'd1 : 2'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
